// File: rtl/sargantana_icache_flush_pkg.sv
// Shared types for the icache flush sequencer.
package sargantana_icache_flush_pkg;

  // Flush scope requested by the core.
  typedef enum logic {
    FLUSH_ALL = 1'b0,
    FLUSH_SET = 1'b1
  } flush_mode_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } flush_state_e;

endpackage

// File: rtl/sargantana_icache_flush_seq.sv
// Sequences invalidation writes into the icache tag/valid array, one set per
// accepted beat, with a one-deep slot for a request arriving mid-flush.
module sargantana_icache_flush_seq
  import sargantana_icache_flush_pkg::*;
#(
  parameter int ICACHE_DEPTH = 64,
  parameter int NUM_WAYS     = 4,
  localparam int ADDR_WIDTH  = $clog2(ICACHE_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  flush_req_i,
  input  logic                  flush_mode_i,
  input  logic [ADDR_WIDTH-1:0] flush_set_i,
  input  logic [NUM_WAYS-1:0]   flush_way_mask_i,
  output logic                  flush_ack_o,
  output logic                  inval_valid_o,
  input  logic                  inval_ready_i,
  output logic [ADDR_WIDTH-1:0] inval_addr_o,
  output logic [NUM_WAYS-1:0]   inval_way_mask_o,
  output logic                  busy_o,
  output logic                  flush_done_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(ICACHE_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(ICACHE_DEPTH);

  // Request with set clamped and mask already resolved.
  typedef struct packed {
    flush_mode_e           mode;
    logic [ADDR_WIDTH-1:0] set;
    logic [NUM_WAYS-1:0]   mask;
  } flush_req_t;

  // An all-zero mask means every way; out-of-range sets clamp to the last set.
  function automatic flush_req_t resolve(input logic mode,
                                         input logic [ADDR_WIDTH-1:0] set,
                                         input logic [NUM_WAYS-1:0] mask);
    flush_req_t r;
    r.mode = flush_mode_e'(mode);
    r.set  = ({1'b0, set} >= DEPTH_W) ? LAST_IDX : set;
    r.mask = (mask == '0) ? '1 : mask;
    return r;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] first_idx(input flush_req_t r);
    return (r.mode == FLUSH_ALL) ? '0 : r.set;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] last_idx(input flush_req_t r);
    return (r.mode == FLUSH_ALL) ? LAST_IDX : r.set;
  endfunction

  flush_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] end_q, end_d;
  logic [NUM_WAYS-1:0]   mask_q, mask_d;
  logic                  pend_valid_q, pend_valid_d;
  flush_req_t            pend_q, pend_d;
  flush_req_t            incoming, load_req;
  logic                  ack, load;

  assign incoming = resolve(flush_mode_i, flush_set_i, flush_way_mask_i);

  // State, counter, active request and pending slot registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      end_q        <= '0;
      mask_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      end_q        <= end_d;
      mask_q       <= mask_d;
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;
    end
  end

  // Next-state, request acceptance and active-request loading.
  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    end_d        = end_q;
    mask_d       = mask_q;
    pend_valid_d = pend_valid_q;
    pend_d       = pend_q;
    ack          = 1'b0;
    load         = 1'b0;
    load_req     = incoming;
    unique case (state_q)
      IDLE: begin
        ack  = flush_req_i;
        load = flush_req_i;
      end
      RUN: begin
        ack = flush_req_i && !pend_valid_q;
        if (ack) begin
          pend_valid_d = 1'b1;
          pend_d       = incoming;
        end
        // Terminal compare comes first, so the counter never steps past end.
        if (inval_ready_i) begin
          if (cnt_q == end_q) state_d = DONE;
          else                cnt_d   = cnt_q + ADDR_WIDTH'(1);
        end
      end
      DONE: begin
        if (pend_valid_q) begin
          load         = 1'b1;
          load_req     = pend_q;
          pend_valid_d = 1'b0;
        end else begin
          ack  = flush_req_i;
          load = flush_req_i;
          if (!flush_req_i) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = RUN;
      cnt_d   = first_idx(load_req);
      end_d   = last_idx(load_req);
      mask_d  = load_req.mask;
    end
  end

  // Outputs are forced low while reset is asserted.
  assign flush_ack_o      = rstn_i & ack;
  assign inval_valid_o    = (state_q == RUN);
  assign inval_addr_o     = (state_q == RUN) ? cnt_q : '0;
  assign inval_way_mask_o = (state_q == RUN) ? mask_q : '0;
  assign busy_o           = (state_q != IDLE);
  assign flush_done_o     = (state_q == DONE);

endmodule

// File: tb/tb_sargantana_icache_flush_seq.sv
// Directed bench for the icache flush sequencer: a 4-set/2-way instance and a
// 5-set/2-way instance, with accepted beats scored against expected queues.
module tb_sargantana_icache_flush_seq;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: ICACHE_DEPTH=4, NUM_WAYS=2
  logic       a_req, a_mode, a_ack, a_valid, a_ready, a_busy, a_done;
  logic [1:0] a_set, a_mask, a_addr, a_wmask;
  // Instance B: ICACHE_DEPTH=5, NUM_WAYS=2
  logic       b_req, b_mode, b_ack, b_valid, b_ready, b_busy, b_done;
  logic [2:0] b_set, b_addr;
  logic [1:0] b_mask, b_wmask;

  sargantana_icache_flush_seq #(.ICACHE_DEPTH(4), .NUM_WAYS(2)) dut_a (
    .clk_i(clk), .rstn_i(rstn), .flush_req_i(a_req), .flush_mode_i(a_mode),
    .flush_set_i(a_set), .flush_way_mask_i(a_mask), .flush_ack_o(a_ack),
    .inval_valid_o(a_valid), .inval_ready_i(a_ready), .inval_addr_o(a_addr),
    .inval_way_mask_o(a_wmask), .busy_o(a_busy), .flush_done_o(a_done)
  );

  sargantana_icache_flush_seq #(.ICACHE_DEPTH(5), .NUM_WAYS(2)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .flush_req_i(b_req), .flush_mode_i(b_mode),
    .flush_set_i(b_set), .flush_way_mask_i(b_mask), .flush_ack_o(b_ack),
    .inval_valid_o(b_valid), .inval_ready_i(b_ready), .inval_addr_o(b_addr),
    .inval_way_mask_o(b_wmask), .busy_o(b_busy), .flush_done_o(b_done)
  );

  // Expected beats packed as {addr, mask}.
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input int addr, input int mask);
    qa.push_back(32'((addr << 2) | mask));
  endtask

  task automatic push_b(input int addr, input int mask);
    qb.push_back(32'((addr << 2) | mask));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Score every accepted beat, mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (a_valid && a_ready) begin
      check("a_beat_expected", 32'(qa.size() > 0), 32'd1);
      if (qa.size() > 0) check("a_beat", 32'({a_addr, a_wmask}), qa.pop_front());
    end
    if (b_valid && b_ready) begin
      check("b_beat_expected", 32'(qb.size() > 0), 32'd1);
      if (qb.size() > 0) check("b_beat", 32'({b_addr, b_wmask}), qb.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    a_req = 0; a_mode = 0; a_set = 0; a_mask = 0; a_ready = 1;
    b_req = 0; b_mode = 0; b_set = 0; b_mask = 0; b_ready = 1;
    #2;
    check("rst_a_outputs", 32'({a_ack, a_valid, a_busy, a_done, a_addr, a_wmask}), 32'd0);
    check("rst_b_outputs", 32'({b_ack, b_valid, b_busy, b_done, b_addr, b_wmask}), 32'd0);
    #10 rstn = 1'b1;

    // T1: full flush, mask 11, ready high.
    step(); a_req = 1; a_mode = 0; a_set = 0; a_mask = 2'b11;
    for (int i = 0; i < 4; i++) push_a(i, 3);
    #1 check("t1_ack", 32'(a_ack), 32'd1);
    check("t1_idle_busy", 32'(a_busy), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step(); a_req = 0;
      #1 check("t1_valid", 32'(a_valid), 32'd1);
      check("t1_addr", 32'(a_addr), 32'(i - 1));
      check("t1_no_done", 32'(a_done), 32'd0);
    end
    step(); #1 check("t1_done", 32'({a_done, a_valid}), 32'b10);
    step(); #1 check("t1_idle", 32'({a_busy, a_done}), 32'b00);

    // T2: single set 2, mask 01, ready low for 3 cycles.
    step(); a_req = 1; a_mode = 1; a_set = 2; a_mask = 2'b01; a_ready = 0;
    push_a(2, 1);
    #1 check("t2_ack", 32'(a_ack), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      step(); a_req = 0;
      #1 check("t2_hold", 32'({a_valid, a_addr, a_wmask}), 32'b1_10_01);
      check("t2_no_done", 32'(a_done), 32'd0);
    end
    step(); a_ready = 1;
    #1 check("t2_beat", 32'({a_valid, a_addr, a_wmask}), 32'b1_10_01);
    step(); #1 check("t2_done", 32'({a_done, a_valid}), 32'b10);
    step(); #1 check("t2_idle", 32'(a_busy), 32'd0);

    // T3: zero mask in full mode means all ways.
    step(); a_req = 1; a_mode = 0; a_set = 3; a_mask = 2'b00;
    for (int i = 0; i < 4; i++) push_a(i, 3);
    for (int i = 1; i <= 4; i++) begin step(); a_req = 0; end
    step(); #1 check("t3_done", 32'(a_done), 32'd1);
    step(); #1 check("t3_idle", 32'(a_busy), 32'd0);

    // T4: single-set request queued on cycle 2 of a full flush.
    step(); a_req = 1; a_mode = 0; a_mask = 2'b11;
    for (int i = 0; i < 4; i++) push_a(i, 3);
    step(); a_req = 0;
    step(); a_req = 1; a_mode = 1; a_set = 1; a_mask = 2'b10;
    push_a(1, 2);
    #1 check("t4_pend_ack", 32'(a_ack), 32'd1);
    step(); a_req = 0;
    #1 check("t4_no_reack", 32'(a_ack), 32'd0);
    step();
    step(); #1 check("t4_done1", 32'(a_done), 32'd1);
    step(); #1 check("t4_second_beat", 32'({a_valid, a_addr, a_wmask}), 32'b1_01_10);
    step(); #1 check("t4_done2", 32'(a_done), 32'd1);
    step(); #1 check("t4_idle", 32'(a_busy), 32'd0);

    // T5: third request while the slot is full.
    step(); a_req = 1; a_mode = 0; a_mask = 2'b11;
    for (int i = 0; i < 4; i++) push_a(i, 3);
    step(); a_req = 1; a_mode = 1; a_set = 3; a_mask = 2'b01;
    push_a(3, 1);
    #1 check("t5_slot_ack", 32'(a_ack), 32'd1);
    step(); a_set = 0; a_mask = 2'b10;
    #1 check("t5_full_c2", 32'(a_ack), 32'd0);
    step(); #1 check("t5_full_c3", 32'(a_ack), 32'd0);
    step(); #1 check("t5_full_c4", 32'(a_ack), 32'd0);
    step(); #1 check("t5_done_noack", 32'({a_done, a_ack}), 32'b10);
    step();
    #1 check("t5_third_ack", 32'(a_ack), 32'd1);
    check("t5_second_beat", 32'({a_valid, a_addr}), 32'b1_11);
    push_a(0, 2);
    step(); a_req = 0;
    #1 check("t5_done2", 32'(a_done), 32'd1);
    step(); #1 check("t5_third_beat", 32'({a_valid, a_addr, a_wmask}), 32'b1_00_10);
    step(); #1 check("t5_done3", 32'(a_done), 32'd1);
    step(); #1 check("t5_idle", 32'(a_busy), 32'd0);

    // T6: reset during the addr 2 beat.
    step(); a_req = 1; a_mode = 0; a_mask = 2'b11;
    push_a(0, 3); push_a(1, 3);
    step(); a_req = 0;
    step();
    step(); rstn = 1'b0;
    #1 check("t6_rst_outputs", 32'({a_ack, a_valid, a_busy, a_done, a_addr, a_wmask}), 32'd0);
    step(); #1 check("t6_rst_hold", 32'({a_valid, a_done}), 32'd0);
    rstn = 1'b1;
    step(); #1 check("t6_no_done", 32'({a_busy, a_done}), 32'd0);
    step(); #1 check("t6_still_idle", 32'({a_busy, a_done}), 32'd0);
    step(); a_req = 1;
    for (int i = 0; i < 4; i++) push_a(i, 3);
    step(); a_req = 0;
    #1 check("t6_restart_addr0", 32'({a_valid, a_addr}), 32'b1_00);
    for (int i = 2; i <= 4; i++) step();
    step(); #1 check("t6_done", 32'(a_done), 32'd1);

    // T7: ICACHE_DEPTH=5 full flush, then out-of-range set clamp.
    step(); b_req = 1; b_mode = 0; b_mask = 2'b01;
    for (int i = 0; i < 5; i++) push_b(i, 1);
    #1 check("t7_ack", 32'(b_ack), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      step(); b_req = 0;
      #1 check("t7_addr", 32'({b_valid, b_addr}), 32'({1'b1, 3'(i - 1)}));
    end
    step(); #1 check("t7_done", 32'({b_done, b_valid}), 32'b10);
    step(); #1 check("t7_idle", 32'(b_busy), 32'd0);
    step(); b_req = 1; b_mode = 1; b_set = 3'd7; b_mask = 2'b10;
    push_b(4, 2);
    step(); b_req = 0;
    #1 check("t7_clamp", 32'({b_valid, b_addr}), 32'b1_100);
    step(); #1 check("t7_clamp_done", 32'(b_done), 32'd1);

    step();
    check("a_queue_drained", 32'(qa.size()), 32'd0);
    check("b_queue_drained", 32'(qb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
